typing_round_monitor: RTL and testbench
=======================================

Name: typing_round_monitor

Overview:
- Controls the elapsed-time counter for one typing round and consumes its output.
- Drives the counter's clear and enable lines, and reads back its 4-bit wrapping elapsed-time value.
- Extends that value to a wider non-wrapping time and counts correct and incorrect keystrokes.
- Ends the round on stop, time limit or error limit, and latches the results for the score/display logic.

Parameters:
TIME_W, 4, width of elapsed-time input from the counter (wraps at 2^TIME_W)
EXT_W, 8, width of extended elapsed time and final_time
CNT_W, 8, width of correct/error keystroke counters
TIME_LIMIT, 60, extended-time value at which the round times out
MAX_ERRORS, 10, error count at which the round aborts

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a new round (level, sampled in IDLE/DONE)
stop  in  1  user ends round (sampled in RUN)
time_in  in  TIME_W  elapsed time from counter, wraps 2^TIME_W-1 -> 0
char_valid  in  1  one keystroke judged this cycle
char_correct  in  1  keystroke matched target (qualified by char_valid)
timer_clear  out  1  registered; clears the counter
timer_enable  out  1  registered; counter runs while high
round_active  out  1  high in RUN
done  out  1  high in DONE, held
end_reason  out  2  00 none, 01 stop, 10 timeout, 11 error limit
final_time  out  EXT_W  extended time latched at round end
correct_count  out  CNT_W  correct keystrokes this round
error_count  out  CNT_W  incorrect keystrokes this round

Behaviour:
- All outputs registered. Reset has priority over every other input, in any state including mid-round. On reset: state IDLE; every output 0; internal wrap counter and prev_time 0.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE: start=1 -> ARM. Otherwise stay; outputs 0.
- ARM (exactly 1 cycle):
  - timer_clear=1, timer_enable=0.
  - Clears correct_count, error_count, final_time, end_reason, done, wrap counter, prev_time.
  - Next state RUN unconditionally.
- RUN:
  - timer_clear=0, timer_enable=1, round_active=1.
  - Wrap extension each cycle: if time_in < prev_time, wrap counter +1. prev_time <= time_in.
  - ext_time = wrap*2^TIME_W + time_in, saturating at 2^EXT_W-1 (wrap counter stops incrementing once saturated).
  - Keystroke counting: when char_valid=1, char_correct=1 increments correct_count, else error_count; both saturate at 2^CNT_W-1.
  - Keystrokes arriving in the same cycle as an exit condition are counted.
  - Exit checks, in priority order:
    - stop=1 -> end_reason 01.
    - ext_time >= TIME_LIMIT -> end_reason 10.
    - error count after this cycle's update >= MAX_ERRORS -> end_reason 11.
  - On exit: final_time <= ext_time of that cycle; next state DONE.
  - start is ignored in RUN.
- DONE:
  - timer_enable=0, round_active=0, done=1.
  - final_time, end_reason and counters held. char_valid and stop are ignored.
  - start=1 -> ARM (new round). No other exit except reset.
- Counter contract:
  - The counter samples timer_clear at the next clock edge, so time_in=0 in the first RUN cycle.
  - The monitor tolerates time_in advancing by at most 1 per cycle; larger jumps are not detected as extra wraps.
- Latency:
  - start -> timer_clear: 1 cycle.
  - start -> round_active: 2 cycles.
  - Exit condition -> done: 1 cycle.

Test Plan:
- Reset mid-RUN with correct_count=5, then reset=1 for 1 cycle -> next cycle state IDLE, all outputs 0, timer_enable=0.
- start pulse in IDLE -> cycle+1 timer_clear=1 (for 1 cycle only), cycle+2 timer_enable=1 and round_active=1, counters 0.
- Wrap extension (TIME_W=4): drive time_in 0..15,0..15,0..3 -> internal ext_time reaches 35; assert stop -> final_time=35, end_reason=01, done=1.
- Timeout (TIME_LIMIT=20): time_in ramps 0..15,0..4 -> done the cycle after time_in=4, final_time=20, end_reason=10; later char_valid pulses leave the counts unchanged.
- Error limit (MAX_ERRORS=3): 4 correct + 3 incorrect keystrokes -> done after the 3rd error, correct_count=4, error_count=3, end_reason=11.
- Simultaneous events: stop=1, time at limit and char_valid=1/char_correct=0 in the same cycle -> end_reason=01, error_count incremented. Then start in DONE -> ARM, counters cleared.

Source files
------------

// File: rtl/typing_round_monitor.sv
// Round controller for a typing test: drives the elapsed-time counter, extends its
// wrapping output to a wider time base, counts keystrokes and latches the round result.
module typing_round_monitor #(
  parameter int TIME_W     = 4,
  parameter int EXT_W      = 8,
  parameter int CNT_W      = 8,
  parameter int TIME_LIMIT = 60,
  parameter int MAX_ERRORS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [TIME_W-1:0] time_in,
  input  logic              char_valid,
  input  logic              char_correct,
  output logic              timer_clear,
  output logic              timer_enable,
  output logic              round_active,
  output logic              done,
  output logic [1:0]        end_reason,
  output logic [EXT_W-1:0]  final_time,
  output logic [CNT_W-1:0]  correct_count,
  output logic [CNT_W-1:0]  error_count
);

  localparam int WRAP_W = EXT_W - TIME_W;
  localparam logic [EXT_W-1:0] TIME_LIMIT_C = EXT_W'(TIME_LIMIT);
  localparam logic [CNT_W-1:0] MAX_ERRORS_C = CNT_W'(MAX_ERRORS);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_e;

  localparam logic [1:0] REASON_NONE  = 2'b00;
  localparam logic [1:0] REASON_STOP  = 2'b01;
  localparam logic [1:0] REASON_TIME  = 2'b10;
  localparam logic [1:0] REASON_ERROR = 2'b11;

  state_e            state_q, state_d;
  // Extra top bit marks that the extended time has reached its ceiling.
  logic [WRAP_W:0]   wrap_q, wrap_d;
  logic [TIME_W-1:0] prev_time_q, prev_time_d;
  logic [CNT_W-1:0]  correct_q, correct_d;
  logic [CNT_W-1:0]  error_q, error_d;
  logic [1:0]        end_reason_q, end_reason_d;
  logic [EXT_W-1:0]  final_time_q, final_time_d;
  logic              timer_clear_q, timer_clear_d;
  logic              timer_enable_q, timer_enable_d;
  logic              round_active_q, round_active_d;
  logic              done_q, done_d;

  logic [WRAP_W:0]   wrap_step;
  logic [EXT_W-1:0]  ext_time;
  logic [CNT_W-1:0]  correct_step;
  logic [CNT_W-1:0]  error_step;

  // NOTE: every variable gets a default at the top so no path leaves one unassigned
  // (which would infer a latch).
  always_comb begin
    state_d      = state_q;
    wrap_d       = wrap_q;
    prev_time_d  = prev_time_q;
    correct_d    = correct_q;
    error_d      = error_q;
    end_reason_d = end_reason_q;
    final_time_d = final_time_q;

    wrap_step = wrap_q;
    if ((time_in < prev_time_q) && !wrap_q[WRAP_W]) begin
      wrap_step = wrap_q + (WRAP_W+1)'(1);
    end
    ext_time = wrap_step[WRAP_W] ? '1 : {wrap_step[WRAP_W-1:0], time_in};

    correct_step = correct_q;
    error_step   = error_q;
    if (char_valid && char_correct && (correct_q != '1)) begin
      correct_step = correct_q + CNT_W'(1);
    end
    if (char_valid && !char_correct && (error_q != '1)) begin
      error_step = error_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM:  state_d = S_RUN;
      S_RUN: begin
        wrap_d      = wrap_step;
        prev_time_d = time_in;
        correct_d   = correct_step;
        error_d     = error_step;
        if (stop) begin
          state_d      = S_DONE;
          end_reason_d = REASON_STOP;
          final_time_d = ext_time;
        end else if (ext_time >= TIME_LIMIT_C) begin
          state_d      = S_DONE;
          end_reason_d = REASON_TIME;
          final_time_d = ext_time;
        end else if (error_step >= MAX_ERRORS_C) begin
          state_d      = S_DONE;
          end_reason_d = REASON_ERROR;
          final_time_d = ext_time;
        end
      end
      S_DONE: if (start) state_d = S_ARM;
      default: state_d = S_IDLE;
    endcase

    // Entering ARM wipes the previous round so the results read zero before RUN.
    if (state_d == S_ARM) begin
      wrap_d       = '0;
      prev_time_d  = '0;
      correct_d    = '0;
      error_d      = '0;
      end_reason_d = REASON_NONE;
      final_time_d = '0;
    end

    timer_clear_d  = (state_d == S_ARM);
    timer_enable_d = (state_d == S_RUN);
    round_active_d = (state_d == S_RUN);
    done_d         = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wrap_q         <= '0;
      prev_time_q    <= '0;
      correct_q      <= '0;
      error_q        <= '0;
      end_reason_q   <= REASON_NONE;
      final_time_q   <= '0;
      timer_clear_q  <= 1'b0;
      timer_enable_q <= 1'b0;
      round_active_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wrap_q         <= wrap_d;
      prev_time_q    <= prev_time_d;
      correct_q      <= correct_d;
      error_q        <= error_d;
      end_reason_q   <= end_reason_d;
      final_time_q   <= final_time_d;
      timer_clear_q  <= timer_clear_d;
      timer_enable_q <= timer_enable_d;
      round_active_q <= round_active_d;
      done_q         <= done_d;
    end
  end

  assign timer_clear   = timer_clear_q;
  assign timer_enable  = timer_enable_q;
  assign round_active  = round_active_q;
  assign done          = done_q;
  assign end_reason    = end_reason_q;
  assign final_time    = final_time_q;
  assign correct_count = correct_q;
  assign error_count   = error_q;

endmodule

// File: tb/tb_typing_round_monitor.sv
// Directed bench: instance a uses default limits, instance b uses TIME_LIMIT=20 and
// MAX_ERRORS=3; both share the same stimulus.
module tb_typing_round_monitor;

  logic       clk = 1'b0;
  logic       reset, start, stop, char_valid, char_correct;
  logic [3:0] time_in;

  logic       a_clear, a_enable, a_active, a_done;
  logic [1:0] a_reason;
  logic [7:0] a_final, a_correct, a_error;
  logic       b_clear, b_enable, b_active, b_done;
  logic [1:0] b_reason;
  logic [7:0] b_final, b_correct, b_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  typing_round_monitor u_dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .time_in(time_in),
    .char_valid(char_valid), .char_correct(char_correct),
    .timer_clear(a_clear), .timer_enable(a_enable), .round_active(a_active),
    .done(a_done), .end_reason(a_reason), .final_time(a_final),
    .correct_count(a_correct), .error_count(a_error)
  );

  typing_round_monitor #(.TIME_LIMIT(20), .MAX_ERRORS(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .time_in(time_in),
    .char_valid(char_valid), .char_correct(char_correct),
    .timer_clear(b_clear), .timer_enable(b_enable), .round_active(b_active),
    .done(b_done), .end_reason(b_reason), .final_time(b_final),
    .correct_count(b_correct), .error_count(b_error)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; time_in = 0; char_valid = 0; char_correct = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic begin_round();
    start = 1;
    tick();
    start = 0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_clear, a_enable, a_active, a_done, a_reason, a_final, a_correct, a_error} !== '0) begin
      errors++; $display("FAIL reset_init: outputs=%h expected 0",
        {a_clear, a_enable, a_active, a_done, a_reason, a_final, a_correct, a_error});
    end
    begin_round();
    for (int k = 0; k < 5; k++) begin
      time_in = 4'(k); char_valid = 1; char_correct = 1;
      tick();
    end
    char_valid = 0;
    checks++;
    if (a_correct !== 8'd5) begin
      errors++; $display("FAIL reset_pre_count: correct=%0d expected 5", a_correct);
    end
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if ({a_clear, a_enable, a_active, a_done, a_reason, a_final, a_correct, a_error} !== '0) begin
      errors++; $display("FAIL reset_mid_run: outputs=%h expected 0",
        {a_clear, a_enable, a_active, a_done, a_reason, a_final, a_correct, a_error});
    end
    tick();
    checks++;
    if ({a_clear, a_enable, a_active, a_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_stays_idle: ctrl=%b expected 0000",
        {a_clear, a_enable, a_active, a_done});
    end
  endtask

  task automatic test_start();
    do_reset();
    start = 1;
    tick();
    start = 0;
    checks++;
    if ({a_clear, a_enable, a_active} !== 3'b100) begin
      errors++; $display("FAIL start_arm: clear/enable/active=%b expected 100",
        {a_clear, a_enable, a_active});
    end
    tick();
    checks++;
    if ({a_clear, a_enable, a_active, a_correct, a_error} !== {3'b011, 16'h0}) begin
      errors++; $display("FAIL start_run: clear/enable/active=%b counts=%0d/%0d expected 011 0/0",
        {a_clear, a_enable, a_active}, a_correct, a_error);
    end
  endtask

  task automatic test_wrap_stop();
    do_reset();
    begin_round();
    for (int k = 0; k < 35; k++) begin
      time_in = 4'(k % 16);
      tick();
    end
    checks++;
    if (a_done !== 1'b0 || a_active !== 1'b1) begin
      errors++; $display("FAIL wrap_running: done=%b active=%b expected 0 1", a_done, a_active);
    end
    time_in = 4'd3; stop = 1;
    tick();
    stop = 0;
    checks++;
    if (a_done !== 1'b1 || a_final !== 8'd35 || a_reason !== 2'b01) begin
      errors++; $display("FAIL wrap_stop: done=%b final=%0d reason=%b expected 1 35 01",
        a_done, a_final, a_reason);
    end
    checks++;
    if ({a_enable, a_active} !== 2'b00) begin
      errors++; $display("FAIL wrap_done_ctrl: enable/active=%b expected 00", {a_enable, a_active});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    begin_round();
    for (int k = 0; k < 20; k++) begin
      time_in = 4'(k % 16);
      char_valid = (k >= 1 && k <= 3);
      char_correct = (k != 3);
      tick();
    end
    char_valid = 0;
    checks++;
    if (b_done !== 1'b0) begin
      errors++; $display("FAIL timeout_early: done=%b at ext 19 expected 0", b_done);
    end
    time_in = 4'd4;
    tick();
    checks++;
    if (b_done !== 1'b1 || b_final !== 8'd20 || b_reason !== 2'b10) begin
      errors++; $display("FAIL timeout_end: done=%b final=%0d reason=%b expected 1 20 10",
        b_done, b_final, b_reason);
    end
    char_valid = 1; char_correct = 1; tick();
    char_correct = 0; stop = 1; tick();
    char_valid = 0; stop = 0; tick();
    checks++;
    if (b_correct !== 8'd2 || b_error !== 8'd1 || b_done !== 1'b1 || b_final !== 8'd20) begin
      errors++; $display("FAIL timeout_hold: counts=%0d/%0d done=%b final=%0d expected 2/1 1 20",
        b_correct, b_error, b_done, b_final);
    end
  endtask

  task automatic test_error_limit();
    do_reset();
    begin_round();
    char_valid = 1;
    for (int k = 0; k < 6; k++) begin
      char_correct = (k < 4);
      tick();
    end
    checks++;
    if (b_done !== 1'b0 || b_error !== 8'd2) begin
      errors++; $display("FAIL err_before_limit: done=%b errors=%0d expected 0 2", b_done, b_error);
    end
    char_correct = 0;
    tick();
    char_valid = 0;
    checks++;
    if (b_done !== 1'b1 || b_reason !== 2'b11 || b_correct !== 8'd4 || b_error !== 8'd3) begin
      errors++; $display("FAIL err_limit: done=%b reason=%b counts=%0d/%0d expected 1 11 4/3",
        b_done, b_reason, b_correct, b_error);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    begin_round();
    for (int k = 0; k < 20; k++) begin
      time_in = 4'(k % 16);
      tick();
    end
    time_in = 4'd4; stop = 1; char_valid = 1; char_correct = 0;
    tick();
    stop = 0; char_valid = 0;
    checks++;
    if (b_done !== 1'b1 || b_reason !== 2'b01 || b_error !== 8'd1 || b_final !== 8'd20) begin
      errors++; $display("FAIL simul_exit: done=%b reason=%b errors=%0d final=%0d expected 1 01 1 20",
        b_done, b_reason, b_error, b_final);
    end
    time_in = 4'd0; start = 1;
    tick();
    start = 0;
    checks++;
    if ({b_clear, b_done, b_reason, b_final, b_correct, b_error} !== {1'b1, 27'h0}) begin
      errors++; $display("FAIL restart_arm: clear=%b done=%b reason=%b final=%0d counts=%0d/%0d expected 1 0 00 0 0/0",
        b_clear, b_done, b_reason, b_final, b_correct, b_error);
    end
    tick();
    checks++;
    if ({b_clear, b_enable, b_active} !== 3'b011) begin
      errors++; $display("FAIL restart_run: clear/enable/active=%b expected 011",
        {b_clear, b_enable, b_active});
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_start();
    test_wrap_stop();
    test_timeout();
    test_error_limit();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
